// File: rtl/cdc_chan_arbiter_pkg.sv
// cdc_chan_arbiter_pkg: state encoding and parameter defaults shared by the CDC channel arbiter.
package cdc_chan_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_e;
  localparam int HOLD_DEF    = 2;
  localparam int TIMEOUT_DEF = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cdc_chan_arbiter_rr_pick.sv
// rr_pick: round-robin selector; first set request at or after ptr, wrapping modulo N_REQ.
module rr_pick
  import cdc_chan_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [PW-1:0]    idx_o
);
  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] j;
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    sum    = '0;
    j      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(i);
      j   = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : PW'(sum);
      if (!found && req_i[j]) begin
        found     = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = j;
      end
    end
  end
endmodule

// File: rtl/cdc_chan_arbiter.sv
// cdc_chan_arbiter: round-robin arbiter feeding a slow-to-fast CDC channel,
// holding valid for HOLD cycles and waiting for a toggle ack with timeout.
module cdc_chan_arbiter
  import cdc_chan_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int HOLD    = HOLD_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk_a,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    grant,
  output logic [DW-1:0]       ch_data,
  output logic                ch_valid,
  input  logic                ch_ack,
  output logic                busy,
  output logic                timeout_err
);
  localparam int PW = idx_w(N_REQ);
  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, pick_idx;
  logic [N_REQ-1:0] pick, grant_q, grant_d;
  logic [DW-1:0]    data_q, data_d, sel_data;
  logic             valid_q, valid_d, to_q, to_d, pend_q, pend_d;
  logic [3:0]       hold_q, hold_d;
  logic [7:0]       wait_q, wait_d;
  logic [2:0]       sync_q;
  logic             ack_ev;
  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .pick_o(pick),
    .idx_o (pick_idx)
  );
  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the history stage for edge detection
  assign ack_ev      = sync_q[1] ^ sync_q[2];
  assign grant       = grant_q;
  assign ch_data     = data_q;
  assign ch_valid    = valid_q;
  assign timeout_err = to_q;
  assign busy        = state_q != IDLE;
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      pend_q  <= 1'b0;
      hold_q  <= '0;
      wait_q  <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
      sync_q  <= {sync_q[1:0], ch_ack};
    end
  end
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = '0;
    data_d   = data_q;
    valid_d  = valid_q;
    to_d     = 1'b0;
    pend_d   = pend_q;
    hold_d   = hold_q;
    wait_d   = wait_q;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick[i]) sel_data = req_data[i*DW +: DW];
    case (state_q)
      IDLE: if (|req) begin
        state_d = SEND;
        grant_d = pick;
        data_d  = sel_data;
        valid_d = 1'b1;
        pend_d  = 1'b0;
        hold_d  = '0;
        ptr_d   = (pick_idx == PW'(N_REQ-1)) ? '0 : pick_idx + PW'(1);
      end
      SEND: begin
        pend_d = pend_q | ack_ev;
        if (hold_q == 4'(HOLD-1)) begin
          valid_d = 1'b0;
          wait_d  = '0;
          state_d = WAIT_ACK;
        end else hold_d = hold_q + 4'd1;
      end
      // ack is checked before the timeout so a same-cycle ack suppresses timeout_err
      WAIT_ACK: if (ack_ev || pend_q) begin
        pend_d  = 1'b0;
        state_d = GAP;
      end else if (wait_q == 8'(TIMEOUT-1)) begin
        to_d    = 1'b1;
        state_d = GAP;
      end else wait_d = wait_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
endmodule
